// File: rtl/imem_line_responder.sv
// imem_line_responder
//   Responder end of the fetch-stage instruction-memory port. Single-word
//   fetches are served from a one-line (32 B) buffer; a miss refills the
//   line with a 4-beat, 64-bit burst read from backing memory.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   imem_req/addr/rmask   fetch request, sampled only in IDLE
//   imem_rdata/resp       registered response, resp is a 1-cycle pulse
//   bmem_addr/read        burst request (32 B aligned), read is a pulse
//   bmem_ready            backing memory accepts a request this cycle
//   bmem_rdata/rvalid     burst beats, in address order, gaps allowed
module imem_line_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  input  logic        bmem_ready,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);

  typedef enum logic [1:0] {IDLE, ISSUE, FILL} state_t;

  state_t       state, state_next;
  logic         line_valid;
  logic [26:0]  line_tag;
  logic [255:0] line_data;
  logic [31:2]  req_addr;
  logic [3:0]   req_mask;
  logic [1:0]   beat_cnt;

  logic         hit;
  logic         fill_last;
  logic [255:0] line_filled;
  logic [31:0]  hit_word;
  logic [31:0]  fill_word;

  function automatic logic [31:0] mask_word(input logic [31:0] w, input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (m[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    hit         = line_valid && (imem_addr[31:5] == line_tag);
    hit_word    = line_data[{imem_addr[4:2], 5'b0} +: 32];
    // The last beat is not yet in line_data when the response is formed,
    // so the response word is taken from the line with beat 3 spliced in.
    line_filled = {bmem_rdata, line_data[191:0]};
    fill_word   = line_filled[{req_addr[4:2], 5'b0} +: 32];
    fill_last   = (state == FILL) && bmem_rvalid && (beat_cnt == 2'd3);
  end

  always_comb begin
    state_next = state;
    bmem_read  = 1'b0;
    case (state)
      IDLE:  if (imem_req && !hit) state_next = ISSUE;
      ISSUE: if (bmem_ready) begin
               bmem_read  = 1'b1;
               state_next = FILL;
             end
      FILL:  if (fill_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bmem_addr = {req_addr[31:5], 5'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_resp  <= 1'b0;
      imem_rdata <= '0;
      line_valid <= 1'b0;
      line_tag   <= '0;
      req_addr   <= '0;
      req_mask   <= '0;
      beat_cnt   <= '0;
    end else begin
      imem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (imem_req) begin
            if (hit) begin
              imem_resp  <= 1'b1;
              imem_rdata <= mask_word(hit_word, imem_rmask);
            end else begin
              req_addr   <= imem_addr[31:2];
              req_mask   <= imem_rmask;
              line_valid <= 1'b0;
              beat_cnt   <= '0;
            end
          end
        end
        FILL: begin
          if (bmem_rvalid) begin
            // 2-bit counter wraps 3->0 exactly as the FSM leaves FILL
            beat_cnt <= beat_cnt + 2'd1;
            if (beat_cnt == 2'd3) begin
              line_valid <= 1'b1;
              line_tag   <= req_addr[31:5];
              imem_resp  <= 1'b1;
              imem_rdata <= mask_word(fill_word, req_mask);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage needs no reset; line_valid guards its contents.
  always_ff @(posedge clk) begin
    if ((state == FILL) && bmem_rvalid)
      line_data[{beat_cnt, 6'b0} +: 64] <= bmem_rdata;
  end

endmodule

// File: tb/tb_imem_line_responder.sv
module tb_imem_line_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  imem_line_responder dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_ready (bmem_ready),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int resp_cnt = 0;
  int resp_cyc = -1;
  int read_cnt = 0;
  int read_cyc = -1;
  logic [31:0] read_addr = '0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc++;

  // Scoreboard side: every response pops one expected word.
  always @(negedge clk) begin
    logic [31:0] e;
    if (imem_resp) begin
      resp_cnt++;
      resp_cyc = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp: got rdata=%h, required no response", imem_rdata);
      end else begin
        e = exp_q.pop_front();
        if (imem_rdata !== e) begin
          bad++;
          $display("FAIL resp_data: got %h, required %h (cycle %0d)", imem_rdata, e, cyc);
        end
      end
    end
    if (bmem_read) begin
      read_cnt++;
      read_cyc  = cyc;
      read_addr = bmem_addr;
    end
  end

  // Backing-memory contents used for refills and expected data.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if ({a[31:5], 5'b0} == 32'h1eceb000)
      return 32'h11111111 * {29'b0, a[4:2]};
    return {a[31:2], 2'b00} ^ 32'hC3C35A5A;
  endfunction

  function automatic logic [31:0] masked(input logic [31:0] w, input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] beat(input logic [31:0] base, input int j);
    logic [31:0] a;
    a = base + 32'(8 * j);
    return {mem_word(a + 32'd4), mem_word(a)};
  endfunction

  // Stimulus only: a full miss with optional ready stall, beat gaps and a
  // stray beat during ISSUE. k = cycle in which the request is presented.
  task automatic run_miss(input logic [31:0] a, input logic [3:0] m, input int rdly,
                          input int gap, input bit stray, output int k);
    logic [31:0] base;
    base = {a[31:5], 5'b0};
    @(posedge clk); #1;
    k = cyc;
    imem_req = 1'b1; imem_addr = a; imem_rmask = m;
    exp_q.push_back(masked(mem_word(a), m));
    @(posedge clk); #1;
    imem_req = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      bmem_rvalid = stray && (i == 0);
      bmem_rdata  = 64'hDEADBEEF_DEADBEEF;
      @(posedge clk); #1;
    end
    bmem_rvalid = 1'b0;
    bmem_ready  = 1'b1;
    @(posedge clk); #1;
    bmem_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
      bmem_rvalid = 1'b1;
      bmem_rdata  = beat(base, j);
      @(posedge clk); #1;
      bmem_rvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    int rc0, k;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    imem_req = 1'b1; imem_addr = 32'h1eceb000; imem_rmask = 4'hF;
    @(posedge clk); #1;
    imem_req = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bmem_addr !== 32'h1eceb000) begin
      bad++; $display("FAIL issue_addr: got %h, required %h", bmem_addr, 32'h1eceb000);
    end
    #2 bmem_ready = 1'b1; rst = 1'b1;
    #1;
    total++;
    if ({imem_resp, bmem_read, imem_rdata, bmem_addr} !== 66'b0) begin
      bad++;
      $display("FAIL async_reset_outputs: got resp=%b read=%b rdata=%h addr=%h, required all 0",
               imem_resp, bmem_read, imem_rdata, bmem_addr);
    end
    bmem_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    rc0 = read_cnt;
    @(posedge clk); #1;
    k = cyc;
    imem_req = 1'b1; imem_addr = 32'h1eceb000;
    bmem_ready = 1'b1;
    @(posedge clk); #1;
    imem_req = 1'b0;
    @(posedge clk); #1;
    bmem_ready = 1'b0;
    total++;
    if (read_cnt !== rc0 + 1 || read_addr !== 32'h1eceb000 || read_cyc !== k + 1) begin
      bad++;
      $display("FAIL post_reset_miss: got reads=%0d addr=%h cyc=%0d, required 1 %h %0d",
               read_cnt - rc0, read_addr, read_cyc, 32'h1eceb000, k + 1);
    end
    // abandon that refill so the next test starts from IDLE
    #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    int rc0, rd0, k;
    rc0 = resp_cnt; rd0 = read_cnt;
    run_miss(32'h1eceb008, 4'hF, 0, 0, 1'b0, k);
    for (int t = 0; t < 40 && resp_cnt == rc0; t++) begin @(posedge clk); #1; end
    total++;
    if (resp_cnt !== rc0 + 1 || resp_cyc !== k + 6) begin
      bad++;
      $display("FAIL cold_miss_latency: got resps=%0d at cyc %0d, required 1 at %0d",
               resp_cnt - rc0, resp_cyc, k + 6);
    end
    total++;
    if (read_cnt !== rd0 + 1 || read_cyc !== k + 1 || read_addr !== 32'h1eceb000) begin
      bad++;
      $display("FAIL cold_miss_read: got reads=%0d cyc=%0d addr=%h, required 1 %0d %h",
               read_cnt - rd0, read_cyc, read_addr, k + 1, 32'h1eceb000);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    int rc0, rd0;
    addrs[0] = 32'h1eceb000; addrs[1] = 32'h1eceb004; addrs[2] = 32'h1eceb01c;
    rc0 = resp_cnt; rd0 = read_cnt;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      imem_req = 1'b1; imem_addr = addrs[i]; imem_rmask = 4'hF;
      exp_q.push_back(mem_word(addrs[i]));
      @(posedge clk); #1;
    end
    imem_req = 1'b0;
    @(posedge clk); #1;
    total++;
    if (resp_cnt !== rc0 + 3 || read_cnt !== rd0) begin
      bad++;
      $display("FAIL back_to_back: got resps=%0d reads=%0d within 3 cycles, required 3 0",
               resp_cnt - rc0, read_cnt - rd0);
    end
  endtask

  task automatic test_mask();
    logic [3:0] masks [3];
    logic [31:0] addrs [3];
    int rc0;
    masks[0] = 4'b0011; masks[1] = 4'b0000; masks[2] = 4'b1010;
    addrs[0] = 32'h1eceb01c; addrs[1] = 32'h1eceb004; addrs[2] = 32'h1eceb018;
    for (int i = 0; i < 3; i++) begin
      rc0 = resp_cnt;
      @(posedge clk); #1;
      imem_req = 1'b1; imem_addr = addrs[i] | 32'h3; imem_rmask = masks[i];
      exp_q.push_back(masked(mem_word(addrs[i]), masks[i]));
      @(posedge clk); #1;
      imem_req = 1'b0;
      @(posedge clk); #1;
      total++;
      if (resp_cnt !== rc0 + 1) begin
        bad++; $display("FAIL mask_resp_%0d: got %0d resps, required 1", i, resp_cnt - rc0);
      end
    end
    total++;
    if (imem_rdata !== 32'h66006600) begin
      bad++; $display("FAIL rdata_hold: got %h, required %h", imem_rdata, 32'h66006600);
    end
  endtask

  task automatic test_stalled_refill();
    int rc0, rd0, k;
    rc0 = resp_cnt; rd0 = read_cnt;
    run_miss(32'h1eceb020, 4'hF, 3, 2, 1'b1, k);
    for (int t = 0; t < 40 && resp_cnt == rc0; t++) begin @(posedge clk); #1; end
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (read_cnt !== rd0 + 1 || read_cyc !== k + 4 || read_addr !== 32'h1eceb020) begin
      bad++;
      $display("FAIL stall_read: got reads=%0d cyc=%0d addr=%h, required 1 %0d %h",
               read_cnt - rd0, read_cyc, read_addr, k + 4, 32'h1eceb020);
    end
    total++;
    if (resp_cnt !== rc0 + 1) begin
      bad++; $display("FAIL stall_resp_count: got %0d, required 1", resp_cnt - rc0);
    end
    // words of every beat, including beat 0 which the stray beat would hit
    rc0 = resp_cnt;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      imem_req = 1'b1; imem_addr = 32'h1eceb020 + 32'(4 * i); imem_rmask = 4'hF;
      exp_q.push_back(mem_word(32'h1eceb020 + 32'(4 * i)));
      @(posedge clk); #1;
    end
    imem_req = 1'b0;
    @(posedge clk); #1;
    total++;
    if (resp_cnt !== rc0 + 8 || read_cnt !== rd0 + 1) begin
      bad++;
      $display("FAIL stall_line_hits: got resps=%0d reads=%0d, required 8 1",
               resp_cnt - rc0, read_cnt - rd0);
    end
  endtask

  task automatic test_reset_mid_fill();
    int rc0, rd0, k;
    rc0 = resp_cnt;
    @(posedge clk); #1;
    imem_req = 1'b1; imem_addr = 32'h1eceb048; imem_rmask = 4'hF;
    @(posedge clk); #1;
    imem_req = 1'b0; bmem_ready = 1'b1;
    @(posedge clk); #1;
    bmem_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      bmem_rvalid = 1'b1; bmem_rdata = beat(32'h1eceb040, j);
      @(posedge clk); #1;
    end
    bmem_rvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({imem_resp, imem_rdata, bmem_addr} !== 65'b0) begin
      bad++;
      $display("FAIL mid_fill_reset: got resp=%b rdata=%h addr=%h, required 0",
               imem_resp, imem_rdata, bmem_addr);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      bmem_rvalid = 1'b1; bmem_rdata = 64'hBADBAD00_BADBAD00 + 64'(j);
      @(posedge clk); #1;
    end
    bmem_rvalid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    total++;
    if (resp_cnt !== rc0) begin
      bad++; $display("FAIL aborted_resp: got %0d resps, required 0", resp_cnt - rc0);
    end
    rc0 = resp_cnt; rd0 = read_cnt;
    run_miss(32'h1eceb048, 4'hF, 0, 1, 1'b0, k);
    for (int t = 0; t < 40 && resp_cnt == rc0; t++) begin @(posedge clk); #1; end
    total++;
    if (resp_cnt !== rc0 + 1 || read_cnt !== rd0 + 1 || read_addr !== 32'h1eceb040) begin
      bad++;
      $display("FAIL refill_after_reset: got resps=%0d reads=%0d addr=%h, required 1 1 %h",
               resp_cnt - rc0, read_cnt - rd0, read_addr, 32'h1eceb040);
    end
  endtask

  initial begin
    rst = 1'b1; imem_req = 1'b0; imem_addr = '0; imem_rmask = '0;
    bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_mask();
    test_stalled_refill();
    test_reset_mid_fill();
    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL missing_resps: got %0d outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
